// File: rtl/mac_pkg.sv
// Shared width arithmetic and the final round/shift/saturate step for the MAC datapath.
package mac_pkg;

    localparam int MAX_ACC_BW = 64;

    // $clog2(1) is 0; a single-beat dot product needs no extra accumulator bits.
    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int prod_bw_f(input int bw_in, input int bw_w);
        return bw_in + bw_w;
    endfunction

    function automatic int acc_bw_f(input int bw_in, input int bw_w,
                                    input int log2_no_vecs, input int num_cyc);
        return prod_bw_f(bw_in, bw_w) + log2_no_vecs + clog2_safe(num_cyc) + 1;
    endfunction

    // Returns {ovf, value}; the caller keeps the low bw_out bits of value.
    function automatic logic [MAX_ACC_BW:0] round_shift_sat(
        input logic signed [MAX_ACC_BW-1:0] acc,
        input int                            shift,
        input logic                          round_en,
        input logic                          sat_en,
        input int                            bw_out
    );
        logic signed [MAX_ACC_BW:0] t;
        logic signed [MAX_ACC_BW:0] one;
        logic signed [MAX_ACC_BW:0] hi;
        logic signed [MAX_ACC_BW:0] lo;
        logic                       ovf;
        one = 1;
        t   = {acc[MAX_ACC_BW-1], acc};
        if (round_en && shift > 0) begin
            t = t + (one <<< (shift - 1));
        end
        t   = t >>> shift;
        hi  = (one <<< (bw_out - 1)) - one;
        lo  = -(one <<< (bw_out - 1));
        ovf = 1'b0;
        if (sat_en) begin
            if (t > hi) begin
                t   = hi;
                ovf = 1'b1;
            end else if (t < lo) begin
                t   = lo;
                ovf = 1'b1;
            end
        end
        return {ovf, t[MAX_ACC_BW-1:0]};
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Pipelined binary adder tree, one register per level, with valid/first/last sideband.
module mac_adder_tree #(
    parameter int IN_BW  = 26,
    parameter int LOG2_N = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_first,
    input  logic                           in_last,
    input  logic [(1<<LOG2_N)*IN_BW-1:0]   data_in,
    output logic                           out_valid,
    output logic                           out_first,
    output logic                           out_last,
    output logic [IN_BW-1:0]               sum
);

    localparam int N = 1 << LOG2_N;

    // Level 0 is the unregistered input; each later level halves the node count.
    for (genvar gi = 0; gi <= LOG2_N; gi++) begin : g_lvl
        localparam int W = (N >> gi) * IN_BW;
        logic [W-1:0] lvl_sum;
        logic         lvl_valid;
        logic         lvl_first;
        logic         lvl_last;

        if (gi == 0) begin : g_in
            assign lvl_sum   = data_in;
            assign lvl_valid = in_valid;
            assign lvl_first = in_first;
            assign lvl_last  = in_last;
        end else begin : g_add
            logic [W-1:0] sum_next;
            for (genvar gj = 0; gj < (N >> gi); gj++) begin : g_node
                assign sum_next[gj*IN_BW +: IN_BW] =
                    g_lvl[gi-1].lvl_sum[(2*gj)*IN_BW +: IN_BW] +
                    g_lvl[gi-1].lvl_sum[(2*gj+1)*IN_BW +: IN_BW];
            end

            always_ff @(posedge clk) begin
                lvl_sum   <= sum_next;
                lvl_first <= g_lvl[gi-1].lvl_first;
                lvl_last  <= g_lvl[gi-1].lvl_last;
                if (rst) begin
                    lvl_valid <= 1'b0;
                end else begin
                    lvl_valid <= g_lvl[gi-1].lvl_valid;
                end
            end
        end
    end

    assign sum       = g_lvl[LOG2_N].lvl_sum;
    assign out_valid = g_lvl[LOG2_N].lvl_valid;
    assign out_first = g_lvl[LOG2_N].lvl_first;
    assign out_last  = g_lvl[LOG2_N].lvl_last;

endmodule

// File: rtl/mac_round_sat_fp.sv
// Multi-lane multiply-accumulate: products -> adder tree -> packet accumulator -> round/shift/saturate.
module mac_round_sat_fp
    import mac_pkg::*;
#(
    parameter int LOG2_NO_VECS      = 2,
    parameter int BW_IN             = 16,
    parameter int BW_W              = 2,
    parameter int BW_OUT            = 16,
    parameter int NUM_CYC           = 32,
    parameter int R_SHIFT           = 0,
    parameter int ROUND_EN          = 1,
    parameter int SAT_EN            = 1,
    parameter int USE_UNSIGNED_DATA = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic                                  in_first,
    input  logic                                  in_last,
    input  logic [(1<<LOG2_NO_VECS)*BW_IN-1:0]    data_in,
    input  logic [(1<<LOG2_NO_VECS)*BW_W-1:0]     w_vec,
    output logic                                  out_valid,
    output logic [BW_OUT-1:0]                     data_out,
    output logic                                  out_ovf
);

    localparam int NO_VECS = 1 << LOG2_NO_VECS;
    localparam int PROD_BW = prod_bw_f(BW_IN, BW_W);
    localparam int ACC_BW  = acc_bw_f(BW_IN, BW_W, LOG2_NO_VECS, NUM_CYC);
    localparam int CNT_BW  = $clog2(NUM_CYC + 2);
    localparam logic [CNT_BW-1:0] CNT_MAX   = CNT_BW'(NUM_CYC + 1);
    localparam logic [CNT_BW-1:0] CNT_LIMIT = CNT_BW'(NUM_CYC);

    logic [NO_VECS*ACC_BW-1:0] prod_next;
    logic [NO_VECS*ACC_BW-1:0] prod_reg;
    logic                      prod_valid_reg;
    logic                      prod_first_reg;
    logic                      prod_last_reg;

    for (genvar gi = 0; gi < NO_VECS; gi++) begin : g_lane
        logic signed [PROD_BW-1:0] d_s, w_s, p_s;
        logic        [PROD_BW-1:0] d_u, w_u, p_u;
        assign d_s = {{BW_W{data_in[gi*BW_IN+BW_IN-1]}}, data_in[gi*BW_IN +: BW_IN]};
        assign w_s = {{BW_IN{w_vec[gi*BW_W+BW_W-1]}}, w_vec[gi*BW_W +: BW_W]};
        assign d_u = {{BW_W{1'b0}}, data_in[gi*BW_IN +: BW_IN]};
        assign w_u = {{BW_IN{1'b0}}, w_vec[gi*BW_W +: BW_W]};
        assign p_s = d_s * w_s;
        assign p_u = d_u * w_u;
        assign prod_next[gi*ACC_BW +: ACC_BW] = (USE_UNSIGNED_DATA != 0)
            ? {{(ACC_BW-PROD_BW){1'b0}}, p_u}
            : {{(ACC_BW-PROD_BW){p_s[PROD_BW-1]}}, p_s};
    end

    always_ff @(posedge clk) begin
        prod_reg       <= prod_next;
        prod_first_reg <= in_first;
        prod_last_reg  <= in_last;
        if (rst) begin
            prod_valid_reg <= 1'b0;
        end else begin
            prod_valid_reg <= in_valid;
        end
    end

    logic              tree_valid;
    logic              tree_first;
    logic              tree_last;
    logic [ACC_BW-1:0] tree_sum;

    mac_adder_tree #(
        .IN_BW  (ACC_BW),
        .LOG2_N (LOG2_NO_VECS)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (prod_valid_reg),
        .in_first  (prod_first_reg),
        .in_last   (prod_last_reg),
        .data_in   (prod_reg),
        .out_valid (tree_valid),
        .out_first (tree_first),
        .out_last  (tree_last),
        .sum       (tree_sum)
    );

    logic [ACC_BW-1:0] acc_reg;
    logic [ACC_BW-1:0] acc_next;
    logic [CNT_BW-1:0] cnt_reg;
    logic [CNT_BW-1:0] cnt_next;
    logic              fin_valid_reg;

    // A first beat restarts both sum and count, silently dropping any open packet.
    assign acc_next = tree_first ? tree_sum : acc_reg + tree_sum;
    assign cnt_next = tree_first ? CNT_BW'(1)
                    : (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            fin_valid_reg <= 1'b0;
        end else begin
            fin_valid_reg <= tree_valid & tree_last;
            if (tree_valid) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_next;
            end
        end
    end

    logic [MAX_ACC_BW:0] rss;
    logic                rss_unused;
    assign rss = round_shift_sat(MAX_ACC_BW'($signed(acc_reg)), R_SHIFT,
                                 ROUND_EN != 0, SAT_EN != 0, BW_OUT);
    assign rss_unused = ^rss[MAX_ACC_BW-1:BW_OUT];

    logic              out_valid_reg;
    logic [BW_OUT-1:0] data_out_reg;
    logic              out_ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            data_out_reg  <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            out_valid_reg <= fin_valid_reg;
            if (fin_valid_reg) begin
                data_out_reg <= rss[BW_OUT-1:0];
                out_ovf_reg  <= rss[MAX_ACC_BW] | (cnt_reg > CNT_LIMIT);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;
    assign out_ovf   = out_ovf_reg;

endmodule
